// File: rtl/split_packer.sv
// split_packer: serial-to-parallel packer with ready/valid on both sides.
// Collects N_OUT_STREAMS samples of WIDTH bits into one word, realigns on
// in_first (flagging discarded partial words), and supports either lane order.
// Optional feature macro: SPLIT_PACKER_STATUS_EN adds the saturating drop_count port.
module split_packer #(
   parameter int unsigned N_OUT_STREAMS     = 4,
   parameter int unsigned LOG_N_OUT_STREAMS = 2,
   parameter int unsigned WIDTH             = 32,
   parameter int unsigned MSB_FIRST         = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [WIDTH-1:0]                 in_data,
   input  logic                             in_nd,
   input  logic                             in_first,
   output logic                             in_ready,
   output logic [WIDTH*N_OUT_STREAMS-1:0]   out_data,
   output logic                             out_nd,
   input  logic                             out_ready,
   output logic                             out_misaligned
`ifdef SPLIT_PACKER_STATUS_EN
   ,
   output logic [15:0]                      drop_count
`endif
);

   localparam int unsigned OUT_W = WIDTH * N_OUT_STREAMS;
   localparam logic [LOG_N_OUT_STREAMS-1:0] LAST = LOG_N_OUT_STREAMS'(N_OUT_STREAMS - 1);

   logic [LOG_N_OUT_STREAMS-1:0] pos_q;
   logic [LOG_N_OUT_STREAMS-1:0] pos_d;
   logic [LOG_N_OUT_STREAMS-1:0] lane;
   logic [LOG_N_OUT_STREAMS-1:0] slot;
   logic [OUT_W-1:0]             acc_q;
   logic [OUT_W-1:0]             acc_d;
   logic [OUT_W-1:0]             word;
   logic [OUT_W-1:0]             out_data_d;
   logic                         out_nd_d;
   logic                         accept;
   logic                         complete;
   logic                         realign;
   int unsigned                  base;

   // Stall only when a word would complete while the output register is still held
   assign in_ready = !((pos_q == LAST) && out_nd && !out_ready);

   // Next-state: lane selection, accumulator merge, output register load/release
   always_comb begin
      pos_d      = pos_q;
      acc_d      = acc_q;
      out_data_d = out_data;
      out_nd_d   = out_nd;
      accept     = in_nd && in_ready;
      lane       = in_first ? '0 : pos_q;
      slot       = (MSB_FIRST != 0) ? LAST - lane : lane;
      base       = 32'(slot) * WIDTH;
      word       = (lane == '0) ? '0 : acc_q;
      word[base +: WIDTH] = in_data;
      complete   = accept && (lane == LAST);
      realign    = accept && in_first && (pos_q != '0);

      if (out_nd && out_ready) begin
         out_nd_d = 1'b0;
      end
      if (accept) begin
         acc_d = word;
         if (complete) begin
            pos_d      = '0;
            out_data_d = word;
            out_nd_d   = 1'b1;
         end else begin
            pos_d = lane + LOG_N_OUT_STREAMS'(1);
         end
      end
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q          <= '0;
         acc_q          <= '0;
         out_data       <= '0;
         out_nd         <= 1'b0;
         out_misaligned <= 1'b0;
      end else begin
         pos_q          <= pos_d;
         acc_q          <= acc_d;
         out_data       <= out_data_d;
         out_nd         <= out_nd_d;
         out_misaligned <= realign;
      end
   end

`ifdef SPLIT_PACKER_STATUS_EN
   logic [16:0] drop_sum;
   logic [15:0] drop_d;

   // Saturating accumulation of samples discarded by realignment
   always_comb begin
      drop_sum = 17'(drop_count) + 17'(pos_q);
      drop_d   = drop_count;
      if (realign) begin
         drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   // Drop counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= '0;
      end else begin
         drop_count <= drop_d;
      end
   end
`endif

endmodule

// File: tb/tb_split_packer.sv
// Scoreboard bench for split_packer (N=4, WIDTH=8); one instance per lane order.
// Build with SPLIT_PACKER_STATUS_EN defined to also cover drop_count.
module tb_split_packer;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned OW = N * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_nd = 1'b0;
   logic          in_first = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready0, in_ready1, out_nd0, out_nd1, mis0, mis1;
   logic [OW-1:0] out_data0, out_data1;
`ifdef SPLIT_PACKER_STATUS_EN
   logic [15:0]   dc0, dc1;
`endif

   always #5 clk = ~clk;

   split_packer #(.N_OUT_STREAMS(N), .LOG_N_OUT_STREAMS(2), .WIDTH(W), .MSB_FIRST(0)) u0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_first(in_first),
      .in_ready(in_ready0), .out_data(out_data0), .out_nd(out_nd0), .out_ready(out_ready),
      .out_misaligned(mis0)
`ifdef SPLIT_PACKER_STATUS_EN
      , .drop_count(dc0)
`endif
   );

   split_packer #(.N_OUT_STREAMS(N), .LOG_N_OUT_STREAMS(2), .WIDTH(W), .MSB_FIRST(1)) u1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_first(in_first),
      .in_ready(in_ready1), .out_data(out_data1), .out_nd(out_nd1), .out_ready(out_ready),
      .out_misaligned(mis1)
`ifdef SPLIT_PACKER_STATUS_EN
      , .drop_count(dc1)
`endif
   );

   // Reference model: samples of the word in progress, expected words, flags
   logic [W-1:0]  cur[$];
   logic [OW-1:0] q0[$];
   logic [OW-1:0] q1[$];
   bit            mvalid = 0;
   bit            exp_mis = 0;
   bit            just_reset = 0;
   bit            started = 0;
   int            drops = 0;
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] pack(input bit msb);
      logic [OW-1:0] w = '0;
      for (int k = 0; k < cur.size(); k++) begin
         int idx = msb ? (N - 1 - k) : k;
         w[idx*W +: W] = cur[k];
      end
      return w;
   endfunction

   // Apply one cycle of stimulus, advance the model, then check registered outputs
   task automatic drive(input bit r, input bit nd, input bit first, input logic [W-1:0] d, input bit ordy);
      bit ready_m;
      bit acc;
      rst = r; in_nd = nd; in_first = first; in_data = d; out_ready = ordy;
      #1;
      ready_m = !((cur.size() == N - 1) && mvalid && !ordy);
      if (started) begin
         chk("in_ready0", 32'(in_ready0), 32'(ready_m));
         chk("in_ready1", 32'(in_ready1), 32'(ready_m));
      end
      if (r) begin
         cur.delete(); q0.delete(); q1.delete();
         mvalid = 0; exp_mis = 0; drops = 0; just_reset = 1; started = 1;
      end else begin
         just_reset = 0;
         acc = nd && ready_m;
         exp_mis = acc && first && (cur.size() != 0);
         if (mvalid && ordy) mvalid = 0;
         if (acc) begin
            if (first) begin
               drops = (drops + cur.size() > 65535) ? 65535 : drops + cur.size();
               cur.delete();
            end
            cur.push_back(d);
            if (cur.size() == N) begin
               q0.push_back(pack(0));
               q1.push_back(pack(1));
               cur.delete();
               mvalid = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_nd0", 32'(out_nd0), 32'(mvalid));
      chk("out_nd1", 32'(out_nd1), 32'(mvalid));
      chk("misaligned0", 32'(mis0), 32'(exp_mis));
      chk("misaligned1", 32'(mis1), 32'(exp_mis));
      if (just_reset) begin
         chk("rst_data0", out_data0, 32'h0);
         chk("rst_data1", out_data1, 32'h0);
      end
`ifdef SPLIT_PACKER_STATUS_EN
      chk("drop_count0", 32'(dc0), 32'(drops));
      chk("drop_count1", 32'(dc1), 32'(drops));
`endif
   endtask

   // Monitor: pop and compare whenever a word is transferred to the consumer
   initial begin
      logic [OW-1:0] e;
      forever begin
         @(negedge clk);
         if (out_nd0 === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
               failures++;
               $display("FAIL word0 unexpected actual=%h required=none", out_data0);
            end else begin
               e = q0.pop_front();
               if (out_data0 !== e) begin
                  failures++;
                  $display("FAIL word0 actual=%h required=%h", out_data0, e);
               end
            end
         end
         if (out_nd1 === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL word1 unexpected actual=%h required=none", out_data1);
            end else begin
               e = q1.pop_front();
               if (out_data1 !== e) begin
                  failures++;
                  $display("FAIL word1 actual=%h required=%h", out_data1, e);
               end
            end
         end
      end
   end

   // Stimulus: directed scenarios, random traffic, drain, optional saturation
   initial begin
      @(posedge clk);
      #1;
      drive(1, 0, 0, 8'h00, 0);
      drive(1, 0, 0, 8'h00, 0);

      // Back-to-back word, both lane orders
      drive(0, 1, 0, 8'h01, 1);
      drive(0, 1, 0, 8'h02, 1);
      drive(0, 1, 0, 8'h03, 1);
      drive(0, 1, 0, 8'h04, 1);
      chk("t1_word_lsb", out_data0, 32'h04030201);
      chk("t1_word_msb", out_data1, 32'h01020304);
      drive(0, 0, 0, 8'h00, 1);

      // Backpressure: first word held, packer stalls at the last lane
      drive(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 7; i++) drive(0, 1, 0, 8'(8'h11 + i), 0);
      chk("t3_held", out_data0, 32'h14131211);
      chk("t3_stall", 32'(in_ready0), 32'h0);
      drive(0, 1, 0, 8'h18, 0);
      drive(0, 1, 0, 8'h18, 1);
      chk("t3_second", out_data0, 32'h18171615);
      drive(0, 0, 0, 8'h00, 1);

      // Realignment drops a two-sample partial word
      drive(1, 0, 0, 8'h00, 0);
      drive(0, 1, 0, 8'hA1, 1);
      drive(0, 1, 0, 8'hA2, 1);
      drive(0, 1, 1, 8'hB0, 1);
      chk("t4_pulse", 32'(mis0), 32'h1);
      drive(0, 1, 0, 8'hB1, 1);
      chk("t4_single", 32'(mis0), 32'h0);
      drive(0, 1, 0, 8'hB2, 1);
      drive(0, 1, 0, 8'hB3, 1);
      chk("t4_word", out_data0, 32'hB3B2B1B0);
`ifdef SPLIT_PACKER_STATUS_EN
      chk("t4_drops", 32'(dc0), 32'h2);
`endif
      drive(0, 0, 0, 8'h00, 1);

      // Reset discards a partial word
      drive(0, 1, 0, 8'hC1, 1);
      drive(0, 1, 0, 8'hC2, 1);
      drive(0, 1, 0, 8'hC3, 1);
      drive(1, 0, 0, 8'h00, 0);
      chk("t5_rst_nd", 32'(out_nd0), 32'h0);
      drive(0, 1, 0, 8'hD0, 1);
      drive(0, 1, 0, 8'hD1, 1);
      drive(0, 1, 0, 8'hD2, 1);
      chk("t5_no_early_nd", 32'(out_nd0), 32'h0);
      drive(0, 1, 0, 8'hD3, 1);
      chk("t5_word", out_data0, 32'hD3D2D1D0);
      drive(0, 0, 0, 8'h00, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit r;
         r = ($urandom_range(0, 299) == 0);
         drive(r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
               8'($urandom), r ? 1'b0 : ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 1);
      @(negedge clk);
      #1;
      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);

`ifdef SPLIT_PACKER_STATUS_EN
      // Repeated three-sample drops until the counter saturates
      @(posedge clk);
      #1;
      drive(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 21900; i++) begin
         drive(0, 1, 1, 8'($urandom), 1);
         drive(0, 1, 0, 8'($urandom), 1);
         drive(0, 1, 0, 8'($urandom), 1);
      end
      drive(0, 1, 1, 8'h00, 1);
      chk("t6_saturated", 32'(dc0), 32'h0000FFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
